// File: rtl/wasm_linear_mem.sv
// wasm_linear_mem: byte-addressed WASM linear memory with a valid/ready request port,
// 1/2/4/8-byte little-endian access and word-crossing accesses split over two cycles.
// Define LINMEM_BOUNDS_TRAP_EN to trap accesses that run past the end of memory.
module wasm_linear_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_trap
);
    localparam int NB        = DATA_WIDTH / 8;
    localparam int LB        = $clog2(NB);
    localparam int NB2       = 2 * NB;
    localparam int MEM_BYTES = DEPTH * NB;

    typedef enum logic {IDLE, SPLIT} state_t;
    typedef logic [NB-1:0][7:0] word_t;

    word_t                 mem_q [DEPTH];

    state_t                state_q,    state_d;
    logic                  rsp_vld_q,  rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_trap_q, rsp_trap_d;
    logic [LB-1:0]         off_q,      off_d;
    logic [ADDR_WIDTH-1:0] widx_q,     widx_d;
    logic [1:0]            size_q,     size_d;
    logic                  signed_q,   signed_d;
    logic                  we_q,       we_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0] lo_word_q,  lo_word_d;

    logic                  accept;
    logic [LB-1:0]         req_off;
    logic [ADDR_WIDTH-1:0] req_widx;
    logic [ADDR_WIDTH-1:0] hi_widx;
    word_t                 req_word;
    word_t                 hi_word;
    logic                  size_trap;
    logic                  bounds_trap;
    logic                  req_cross;
    logic [NB2-1:0]        req_mask;
    logic [NB2-1:0]        split_mask;
    logic [NB-1:0]         wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    word_t                 wr_lanes;

    // Picks 2^size bytes starting at byte off of the two-word window {hi, lo} and extends them.
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] lo,
        input logic [DATA_WIDTH-1:0] hi,
        input logic [LB-1:0]         off,
        input logic [1:0]            size,
        input logic                  sgn
    );
        logic [2*DATA_WIDTH-1:0] cat;
        logic [DATA_WIDTH-1:0]   raw;
        logic [DATA_WIDTH-1:0]   mask;
        logic [DATA_WIDTH-1:0]   top;
        int                      n;
        n    = 1 << size;
        cat  = {hi, lo} >> (8 * int'(off));
        raw  = cat[DATA_WIDTH-1:0];
        mask = (n >= NB) ? '1 : (DATA_WIDTH'(1) << (8 * n)) - DATA_WIDTH'(1);
        top  = raw >> (8 * n - 1);
        return (raw & mask) | ((sgn && top[0] && (n < NB)) ? ~mask : '0);
    endfunction

    // Lane j of the result carries store byte (j - off) mod NB, serving both halves of a split.
    function automatic logic [DATA_WIDTH-1:0] rot_left(
        input logic [DATA_WIDTH-1:0] d,
        input logic [LB-1:0]         off
    );
        logic [2*DATA_WIDTH-1:0] dbl;
        dbl = {d, d} << (8 * int'(off));
        return dbl[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    // Byte-lane enables over a two-word window; low NB bits hit word widx, high bits widx+1.
    function automatic logic [NB2-1:0] lane_mask(
        input logic [LB-1:0] off,
        input logic [1:0]    size
    );
        logic [NB2-1:0] base;
        base = NB2'((1 << (1 << size)) - 1);
        return base << off;
    endfunction

    assign req_rdy  = (state_q == IDLE) && !rst;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_trap = rsp_trap_q;

    always_comb begin
        accept     = req_vld && req_rdy;
        req_off    = req_addr[LB-1:0];
        req_widx   = req_addr[ADDR_WIDTH+LB-1:LB];
        req_word   = mem_q[req_widx];
        hi_widx    = widx_q + ADDR_WIDTH'(1);
        hi_word    = mem_q[hi_widx];
        size_trap  = (1 << req_size) > NB;
        req_cross  = (int'(req_off) + (1 << req_size)) > NB;
        req_mask   = lane_mask(req_off, req_size);
        split_mask = lane_mask(off_q, size_q);
    end

`ifdef LINMEM_BOUNDS_TRAP_EN
    // 33-bit sum so an access near 4 GiB cannot wrap back into range.
    always_comb begin
        bounds_trap = ({1'b0, req_addr} + 33'(1 << req_size)) > 33'(MEM_BYTES);
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+LB];
    assign bounds_trap      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rsp_vld_d  = 1'b0;
        rsp_data_d = '0;
        rsp_trap_d = 1'b0;
        off_d      = off_q;
        widx_d     = widx_q;
        size_d     = size_q;
        signed_d   = signed_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        lo_word_d  = lo_word_q;
        wr_en      = '0;
        wr_idx     = req_widx;
        wr_lanes   = rot_left(wr_data, req_off);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (size_trap || bounds_trap) begin
                        rsp_vld_d  = 1'b1;
                        rsp_trap_d = 1'b1;
                    end else if (req_cross) begin
                        state_d   = SPLIT;
                        off_d     = req_off;
                        widx_d    = req_widx;
                        size_d    = req_size;
                        signed_d  = req_signed;
                        we_d      = req_we;
                        wdata_d   = wr_data;
                        lo_word_d = req_word;
                        if (req_we) begin
                            wr_en = req_mask[NB-1:0];
                        end
                    end else begin
                        rsp_vld_d = 1'b1;
                        if (req_we) begin
                            wr_en = req_mask[NB-1:0];
                        end else begin
                            rsp_data_d = load_extract(req_word, req_word, req_off,
                                                      req_size, req_signed);
                        end
                    end
                end
            end
            SPLIT: begin
                state_d   = IDLE;
                rsp_vld_d = 1'b1;
                wr_idx    = hi_widx;
                wr_lanes  = rot_left(wdata_q, off_q);
                if (we_q) begin
                    wr_en = split_mask[NB2-1:NB];
                end else begin
                    rsp_data_d = load_extract(lo_word_q, hi_word, off_q, size_q, signed_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_trap_q <= 1'b0;
            off_q      <= '0;
            widx_q     <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            lo_word_q  <= '0;
        end else begin
            state_q    <= state_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_trap_q <= rsp_trap_d;
            off_q      <= off_d;
            widx_q     <= widx_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            lo_word_q  <= lo_word_d;
        end
    end

    // Storage is deliberately not reset; only the enabled lanes of one word change per cycle.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NB; j++) begin
            if (wr_en[j]) begin
                mem_q[wr_idx][j] <= wr_lanes[j];
            end
        end
    end

endmodule
